apb_arb_master: RTL
===================

APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameter ADDR_W, default 5: APB address width.
REQ-002 Parameter DATA_W, default 32: APB data width.
REQ-003 Parameter TIMEOUT, default 16: maximum ACCESS cycles without pready before abort.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  2  per-requester request; held until the matching req_ready.
REQ-007 req_write  input  2  per-requester direction: 1 = write, 0 = read.
REQ-008 req_addr  input  2 x ADDR_W  per-requester address.
REQ-009 req_wdata  input  2 x DATA_W  per-requester write data.
REQ-010 req_ready  output  2  one-cycle accept pulse, one-hot, to the granted requester.
REQ-011 rsp_valid  output  2  one-cycle completion pulse, one-hot, to the granted requester.
REQ-012 rsp_rdata  output  DATA_W  read data; valid only with rsp_valid.
REQ-013 rsp_err  output  1  error flag; valid only with rsp_valid.
REQ-014 psel, penable, pwrite  output  1 each  APB control.
REQ-015 paddr  output  ADDR_W; pwdata  output  DATA_W  APB address and write data.
REQ-016 pready, pslverr  input  1 each; prdata  input  DATA_W  APB slave response.

Function
REQ-017 The FSM SHALL have the states IDLE, SETUP and ACCESS; all outputs SHALL be registered.
REQ-018 In IDLE with any req_valid set, the block SHALL grant one requester, latch its write/addr/wdata, pulse req_ready for that requester in the next cycle, and move to SETUP.
REQ-019 Arbitration SHALL be round-robin: when both requesters are valid, grant the one not granted last; when only one is valid, grant it.
REQ-020 SETUP SHALL drive psel=1 and penable=0 for exactly one cycle, then move to ACCESS.
REQ-021 ACCESS SHALL drive psel=1 and penable=1 until pready=1 is sampled.
REQ-022 paddr, pwrite and pwdata SHALL stay stable from SETUP through the last ACCESS cycle.
REQ-023 On pready=1 in ACCESS, the block SHALL pulse rsp_valid for the granted requester the next cycle, with rsp_rdata=prdata (reads) or 0 (writes) and rsp_err=pslverr, then return to IDLE.
REQ-024 Latency: a request sampled in IDLE at edge k gives SETUP at k+1, ACCESS at k+2, and, with zero-wait pready, rsp_valid at k+3.
REQ-025 If pready stays 0 for TIMEOUT consecutive ACCESS cycles, the block SHALL abort: drop psel/penable, pulse rsp_valid with rsp_err=1 and rsp_rdata=0, and return to IDLE.
REQ-026 At least one IDLE cycle (psel=0) SHALL separate consecutive transfers.
REQ-027 req_valid changes outside IDLE SHALL be ignored until the next IDLE arbitration.
REQ-028 When psel=0, pwdata and paddr SHALL hold their last values; penable SHALL be 0.

Reset
REQ-029 Reset SHALL force IDLE and set psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid, rsp_rdata, rsp_err and the wait counter to 0.
REQ-030 Reset SHALL set the last-grant pointer so that requester 0 wins the first contention.
REQ-031 Reset mid-transfer SHALL drop the in-flight transaction without any rsp_valid.

Structure
REQ-032 Package apb_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS) and the ADDR_W, DATA_W and TIMEOUT defaults.
REQ-033 Sub-module apb_rr_arbiter SHALL implement the 2-way round-robin grant and last-grant pointer; FSM, datapath and timeout counter stay in apb_arb_master.

Verification
REQ-034 Single write: req0 write addr=5, wdata=0xDEADBEEF, pready tied 1 -> SETUP at k+1, ACCESS at k+2, rsp_valid[0] at k+3, rsp_err=0.
REQ-035 Read with 3 wait states: req1 read addr=5, prdata=0x12345678 -> penable held 4 cycles, rsp_rdata=0x12345678 on rsp_valid[1].
REQ-036 Contention: both valid continuously after reset -> grants alternate 0,1,0,1 over four transfers.
REQ-037 Slave error: pslverr=1 with pready=1 on a write -> rsp_err=1 and rsp_rdata=0.
REQ-038 Timeout: pready held 0 -> abort after exactly 16 ACCESS cycles, rsp_err=1, then IDLE.
REQ-039 Reset in ACCESS -> all outputs 0 asynchronously, no rsp_valid; next request is granted to requester 0.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the arbitrated APB master.
//   apb_state_t  - FSM state encoding (IDLE / SETUP / ACCESS)
//   APB_ADDR_W   - default APB address width
//   APB_DATA_W   - default APB data width
//   APB_TIMEOUT  - default ACCESS cycles allowed without pready before abort
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  localparam int APB_ADDR_W  = 5;
  localparam int APB_DATA_W  = 32;
  localparam int APB_TIMEOUT = 16;

endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: 2-way round-robin grant with last-grant pointer.
//   clk, reset - clock and asynchronous active-high reset
//   req        - per-requester valid
//   take       - the grant is being used this cycle; advance the pointer
//   gnt        - index of the requester to serve (meaningful when |req)
module apb_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt
);

  logic last;

  // On contention serve the requester not granted last; otherwise the only one asking.
  assign gnt = (&req) ? ~last : req[1];

  // Pointer resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
    end else if (take) begin
      last <= gnt;
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// apb_arb_master: two requesters arbitrated onto a single APB master port.
//   clk, reset          - clock, asynchronous active-high reset
//   req_valid/write/addr/wdata - per-requester request (flat 2 x W buses)
//   req_ready           - one-cycle accept pulse to the granted requester
//   rsp_valid/rdata/err - one-cycle completion pulse plus read data / error
//   psel/penable/pwrite/paddr/pwdata - APB master outputs
//   pready/pslverr/prdata            - APB slave response
//
// state  | meaning
// IDLE   | no transfer in flight; arbitrate pending requests
// SETUP  | APB setup phase (psel=1, penable=0), exactly one cycle
// ACCESS | APB access phase, waiting for pready or the wait timeout
module apb_arb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  input  logic                pready,
  input  logic                pslverr,
  input  logic [DATA_W-1:0]   prdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  apb_state_t        state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              gnt_id;
  logic              arb_gnt;
  logic              arb_take;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign arb_take  = (state == ST_IDLE) && (|req_valid);
  assign sel_write = arb_gnt ? req_write[1] : req_write[0];
  assign sel_addr  = arb_gnt ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
  assign sel_wdata = arb_gnt ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

  apb_rr_arbiter u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .take  (arb_take),
    .gnt   (arb_gnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      gnt_id    <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            gnt_id    <= arb_gnt;
            pwrite    <= sel_write;
            paddr     <= sel_addr;
            pwdata    <= sel_wdata;
            req_ready <= arb_gnt ? 2'b10 : 2'b01;
            psel      <= 1'b1;
            penable   <= 1'b0;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable  <= 1'b1;
          // Terminal count 0 is reached on the TIMEOUT-th ACCESS cycle.
          wait_cnt <= CNT_W'(TIMEOUT - 1);
          state    <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= gnt_id ? 2'b10 : 2'b01;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
            state     <= ST_IDLE;
          end else if (wait_cnt == '0) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= gnt_id ? 2'b10 : 2'b01;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
